// File: rtl/decomp_pkg.sv
// ============================================================================
// Module   : decomp_pkg
// Purpose  : Shared sizes and FSM state encoding for the codebook decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decomp_pkg;

  localparam int CB_SIZE = 64;    // codewords held in the local codebook
  localparam int TAG_W   = 6;     // tag index width, log2(CB_SIZE)
  localparam int NUM_PIX = 4096;  // tags read / pixels written per frame
  localparam int DATA_W  = 24;    // RAM word: R[23:16] G[15:8] B[7:0]
  localparam int ADDR_W  = 20;    // RAM address width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_CB = 3'd1,
    DECODE  = 3'd2,
    DRAIN   = 3'd3,
    FIN     = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/decompressor_if.sv
// ============================================================================
// Module   : decompressor_if
// Purpose  : Bundle of the three external RAM ports seen by the decoder.
// Ports    : RAM1 (codebook read), RAM2 (tag read), RAM3 (pixel write).
//            modport master - decoder side, drives addresses/enables/data.
//            modport slave  - RAM side, returns read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decompressor_if;
  import decomp_pkg::*;

  logic [DATA_W-1:0] RAM1_Q;
  logic [ADDR_W-1:0] RAM1_A;
  logic              RAM1_OE;
  logic              RAM1_WE;
  logic [DATA_W-1:0] RAM1_D;

  logic [DATA_W-1:0] RAM2_Q;
  logic [ADDR_W-1:0] RAM2_A;
  logic              RAM2_OE;
  logic              RAM2_WE;
  logic [DATA_W-1:0] RAM2_D;

  logic [DATA_W-1:0] RAM3_D;
  logic [ADDR_W-1:0] RAM3_A;
  logic              RAM3_WE;
  logic              RAM3_OE;

  modport master (
    input  RAM1_Q, RAM2_Q,
    output RAM1_A, RAM1_OE, RAM1_WE, RAM1_D,
    output RAM2_A, RAM2_OE, RAM2_WE, RAM2_D,
    output RAM3_D, RAM3_A, RAM3_WE, RAM3_OE
  );

  modport slave (
    output RAM1_Q, RAM2_Q,
    input  RAM1_A, RAM1_OE, RAM1_WE, RAM1_D,
    input  RAM2_A, RAM2_OE, RAM2_WE, RAM2_D,
    input  RAM3_D, RAM3_A, RAM3_WE, RAM3_OE
  );

endinterface

`default_nettype wire

// File: rtl/cb_regfile.sv
// ============================================================================
// Module   : cb_regfile
// Purpose  : Codebook register file, DEPTH x WIDTH flops, one synchronous
//            write port and one combinational read port; cleared on rst.
// Ports    : clk, rst      - clock, asynchronous active-high clear
//            we, wr_idx,   - write strobe / entry index / data
//            wr_data
//            rd_idx        - read entry index
//            rd_data       - entry contents (combinational)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cb_regfile
  import decomp_pkg::*;
#(
  parameter int DEPTH = CB_SIZE,
  parameter int WIDTH = DATA_W,
  parameter int IDX_W = TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] w_entries [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (we && (wr_idx == IDX_W'(i))) begin
        r_q <= wr_data;
      end
    end

    assign w_entries[i] = r_q;
  end

  assign rd_data = w_entries[rd_idx];

endmodule

`default_nettype wire

// File: rtl/decompressor.sv
// ============================================================================
// Module   : decompressor
// Purpose  : Codebook image decoder. Loads CB_SIZE codewords from RAM1, then
//            streams NUM_PIX tags from RAM2, looks each one up and writes the
//            24-bit pixel to RAM3 at one pixel per cycle. done is sticky.
// Ports    : clk, rst  - clock, asynchronous active-high reset
//            bus       - decompressor_if.master (RAM1/RAM2/RAM3 ports)
//            done      - frame complete, held until reset
//            tag_err   - only with DECOMP_TAG_CHECK_EN: sticky flag raised
//                        with the write of a pixel whose tag had upper bits
// Config   : `define DECOMP_TAG_CHECK_EN to reject tags with nonzero bits
//            above TAG_W-1 (pixel written as 0, tag_err set).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decompressor
  import decomp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  decompressor_if.master       bus,
  output logic                 done
`ifdef DECOMP_TAG_CHECK_EN
  ,
  output logic                 tag_err
`endif
);

  localparam logic [ADDR_W-1:0] C_CB_LAST    = ADDR_W'(CB_SIZE - 1);
  localparam logic [ADDR_W-1:0] C_PIX_LAST   = ADDR_W'(NUM_PIX - 1);
  localparam logic [ADDR_W-1:0] C_DRAIN_LAST = ADDR_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;

  // Read-return stage: remembers which request the RAM answers this cycle.
  logic              r_cb_vld;
  logic [TAG_W-1:0]  r_cb_idx;
  logic              r_tag_vld;
  logic [ADDR_W-1:0] r_tag_addr;

  // Write stage driving RAM3.
  logic              r_pix_we;
  logic [ADDR_W-1:0] r_pix_a;
  logic [DATA_W-1:0] r_pix_d;

  logic [DATA_W-1:0] w_cb_rd;
  logic [DATA_W-1:0] w_pix;

  // --------------------------------------------------------------------------
  // FSM: one shared counter serves as RAM1 address, RAM2 address and the
  // drain-cycle count; it is cleared on every state change.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      IDLE: begin
        w_state_nxt = LOAD_CB;
        w_addr_nxt  = '0;
      end
      LOAD_CB: begin
        if (r_addr == C_CB_LAST) begin
          w_state_nxt = DECODE;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      DECODE: begin
        if (r_addr == C_PIX_LAST) begin
          w_state_nxt = DRAIN;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      DRAIN: begin
        if (r_addr == C_DRAIN_LAST) begin
          w_state_nxt = FIN;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
        end
      end
      FIN: begin
        w_state_nxt = FIN;
      end
      default: begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
      end
    endcase
  end

  // Read requests are decoded straight from state so they vanish with rst.
  assign bus.RAM1_OE = (r_state == LOAD_CB);
  assign bus.RAM1_A  = bus.RAM1_OE ? r_addr : '0;
  assign bus.RAM2_OE = (r_state == DECODE);
  assign bus.RAM2_A  = bus.RAM2_OE ? r_addr : '0;

  assign bus.RAM1_WE = 1'b0;
  assign bus.RAM1_D  = '0;
  assign bus.RAM2_WE = 1'b0;
  assign bus.RAM2_D  = '0;
  assign bus.RAM3_OE = 1'b0;

  assign done = (r_state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cb_vld   <= 1'b0;
      r_cb_idx   <= '0;
      r_tag_vld  <= 1'b0;
      r_tag_addr <= '0;
    end else begin
      r_cb_vld   <= bus.RAM1_OE;
      r_cb_idx   <= r_addr[TAG_W-1:0];
      r_tag_vld  <= bus.RAM2_OE;
      r_tag_addr <= r_addr;
    end
  end

  // Entry CB_SIZE-1 lands one cycle before the first tag returns, so the
  // lookup never needs a write-to-read bypass.
  cb_regfile #(
    .DEPTH (CB_SIZE),
    .WIDTH (DATA_W),
    .IDX_W (TAG_W)
  ) u_cb_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (r_cb_vld),
    .wr_idx  (r_cb_idx),
    .wr_data (bus.RAM1_Q),
    .rd_idx  (bus.RAM2_Q[TAG_W-1:0]),
    .rd_data (w_cb_rd)
  );

`ifdef DECOMP_TAG_CHECK_EN
  logic w_tag_bad;
  logic r_tag_err;

  assign w_tag_bad = |bus.RAM2_Q[DATA_W-1:TAG_W];
  assign w_pix     = w_tag_bad ? '0 : w_cb_rd;

  // Registered alongside the pixel so the flag rises with that pixel's write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_err <= 1'b0;
    end else if (r_tag_vld && w_tag_bad) begin
      r_tag_err <= 1'b1;
    end
  end

  assign tag_err = r_tag_err;
`else
  logic w_unused_tag_hi;

  assign w_unused_tag_hi = ^bus.RAM2_Q[DATA_W-1:TAG_W];
  assign w_pix           = w_cb_rd;
`endif

  // Address/data are forced to 0 outside a write so idle outputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_we <= 1'b0;
      r_pix_a  <= '0;
      r_pix_d  <= '0;
    end else begin
      r_pix_we <= r_tag_vld;
      r_pix_a  <= r_tag_vld ? r_tag_addr : '0;
      r_pix_d  <= r_tag_vld ? w_pix : '0;
    end
  end

  assign bus.RAM3_WE = r_pix_we;
  assign bus.RAM3_A  = r_pix_a;
  assign bus.RAM3_D  = r_pix_d;

endmodule

`default_nettype wire

// File: tb/tb_decompressor.sv
// ============================================================================
// Module   : tb_decompressor
// Purpose  : Self-checking bench for decompressor with behavioural RAM1/2/3
//            models (synchronous read, write on WE edge).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decompressor;
  import decomp_pkg::*;

  localparam int PIX_W = $clog2(NUM_PIX);
  localparam int MAX_CYC = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done;
`ifdef DECOMP_TAG_CHECK_EN
  logic tag_err;
`endif

  int errors = 0;
  int checks = 0;
  int edges = 0;          // rising edges since reset release = cycle index
  int wr_count = 0;
  int first_we_cyc = -1;
  int tagerr_cyc = -1;

  logic [DATA_W-1:0] ram1 [CB_SIZE];
  logic [DATA_W-1:0] ram2 [NUM_PIX];
  logic [DATA_W-1:0] ram3 [NUM_PIX];
  logic [DATA_W-1:0] exp3 [NUM_PIX];

  decompressor_if bus ();

  decompressor dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .done    (done)
`ifdef DECOMP_TAG_CHECK_EN
    ,
    .tag_err (tag_err)
`endif
  );

  always #5 clk = ~clk;

  // External RAM models and cycle counter.
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
    if (bus.RAM1_OE === 1'b1) bus.RAM1_Q <= ram1[bus.RAM1_A[TAG_W-1:0]];
    if (bus.RAM2_OE === 1'b1) bus.RAM2_Q <= ram2[bus.RAM2_A[PIX_W-1:0]];
    if (bus.RAM3_WE === 1'b1) ram3[bus.RAM3_A[PIX_W-1:0]] <= bus.RAM3_D;
  end

  // Every-cycle checker: tied outputs and in-order RAM3 writes.
  always @(negedge clk) begin
    if (rst) begin
      wr_count     = 0;
      first_we_cyc = -1;
      tagerr_cyc   = -1;
    end else begin
      checks++;
      if ({bus.RAM1_WE, bus.RAM2_WE, bus.RAM3_OE} !== 3'b000 ||
          bus.RAM1_D !== '0 || bus.RAM2_D !== '0) begin
        errors++;
        $display("FAIL tied_outputs cyc=%0d got WE1=%b WE2=%b OE3=%b D1=%h D2=%h, required all 0",
                 edges, bus.RAM1_WE, bus.RAM2_WE, bus.RAM3_OE, bus.RAM1_D, bus.RAM2_D);
      end
      if (bus.RAM3_WE === 1'b1) begin
        checks++;
        if (bus.RAM3_A !== ADDR_W'(wr_count)) begin
          errors++;
          $display("FAIL wr_addr_order cyc=%0d got %0d required %0d", edges, bus.RAM3_A, wr_count);
        end
        if (first_we_cyc < 0) first_we_cyc = edges;
        wr_count++;
      end
`ifdef DECOMP_TAG_CHECK_EN
      if (tag_err === 1'b1 && tagerr_cyc < 0) tagerr_cyc = edges;
`endif
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic load_pattern();
    for (int k = 0; k < CB_SIZE; k++) begin
      logic [7:0] b;
      b = 8'(k);
      ram1[k] = {b, ~b, b ^ 8'h5A};
    end
    for (int j = 0; j < NUM_PIX; j++) ram2[j] = DATA_W'(j % CB_SIZE);
  endtask

  task automatic build_expected();
    for (int j = 0; j < NUM_PIX; j++) begin
      exp3[j] = ram1[ram2[j][TAG_W-1:0]];
`ifdef DECOMP_TAG_CHECK_EN
      if (ram2[j][DATA_W-1:TAG_W] != '0) exp3[j] = '0;
`endif
      ram3[j] = 'x;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic release_and_wait(output int done_cyc);
    @(posedge clk);
    #1 rst = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < MAX_CYC && done_cyc < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cyc = edges;
    end
  endtask

  function automatic int count_mismatch();
    int m;
    m = 0;
    for (int j = 0; j < NUM_PIX; j++) if (ram3[j] !== exp3[j]) m++;
    return m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.RAM1_OE, bus.RAM2_OE, bus.RAM3_WE, done} !== 4'b0 || bus.RAM1_A !== '0 ||
        bus.RAM2_A !== '0 || bus.RAM3_A !== '0 || bus.RAM3_D !== '0) begin
      errors++;
      $display("FAIL reset_outputs got OE1=%b OE2=%b WE3=%b done=%b A3=%h D3=%h, required all 0",
               bus.RAM1_OE, bus.RAM2_OE, bus.RAM3_WE, done, bus.RAM3_A, bus.RAM3_D);
    end
`ifdef DECOMP_TAG_CHECK_EN
    checks++;
    if (tag_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_tag_err got %b required 0", tag_err);
    end
`endif
  endtask

  task automatic test_pattern();
    int dc;
    int mism;
    load_pattern();
    build_expected();
    apply_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    dc = -1;
    for (int i = 0; i < MAX_CYC && dc < 0; i++) begin
      @(negedge clk);
      case (edges)
        0: begin
          checks++;
          if (bus.RAM1_OE !== 1'b0) begin
            errors++; $display("FAIL idle_cycle got OE1=%b required 0", bus.RAM1_OE);
          end
        end
        1: begin
          checks++;
          if (bus.RAM1_OE !== 1'b1 || bus.RAM1_A !== 20'd0) begin
            errors++; $display("FAIL cb_first got OE1=%b A1=%0d required 1/0", bus.RAM1_OE, bus.RAM1_A);
          end
        end
        64: begin
          checks++;
          if (bus.RAM1_OE !== 1'b1 || bus.RAM1_A !== 20'd63 || bus.RAM2_OE !== 1'b0) begin
            errors++; $display("FAIL cb_last got OE1=%b A1=%0d OE2=%b required 1/63/0",
                               bus.RAM1_OE, bus.RAM1_A, bus.RAM2_OE);
          end
        end
        65: begin
          checks++;
          if (bus.RAM1_OE !== 1'b0 || bus.RAM2_OE !== 1'b1 || bus.RAM2_A !== 20'd0) begin
            errors++; $display("FAIL tag_first got OE1=%b OE2=%b A2=%0d required 0/1/0",
                               bus.RAM1_OE, bus.RAM2_OE, bus.RAM2_A);
          end
        end
        4160: begin
          checks++;
          if (bus.RAM2_OE !== 1'b1 || bus.RAM2_A !== 20'd4095) begin
            errors++; $display("FAIL tag_last got OE2=%b A2=%0d required 1/4095", bus.RAM2_OE, bus.RAM2_A);
          end
        end
        4161: begin
          checks++;
          if (bus.RAM2_OE !== 1'b0 || bus.RAM3_WE !== 1'b1 || bus.RAM3_A !== 20'd4094) begin
            errors++; $display("FAIL drain_write got OE2=%b WE3=%b A3=%0d required 0/1/4094",
                               bus.RAM2_OE, bus.RAM3_WE, bus.RAM3_A);
          end
        end
        default: ;
      endcase
      if (done === 1'b1) dc = edges;
    end
    checks++;
    if (dc != 4163) begin
      errors++; $display("FAIL pattern_done_cycle got %0d required 4163", dc);
    end
    checks++;
    if (first_we_cyc != 67) begin
      errors++; $display("FAIL pattern_first_write got %0d required 67", first_we_cyc);
    end
    checks++;
    if (wr_count != NUM_PIX) begin
      errors++; $display("FAIL pattern_write_count got %0d required %0d", wr_count, NUM_PIX);
    end
    mism = count_mismatch();
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL pattern_contents got %0d bad words required 0", mism);
    end
    checks++;
    if (ram3[70] !== 24'h06F95C) begin
      errors++; $display("FAIL pattern_pixel70 got %h required 06f95c", ram3[70]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || bus.RAM3_WE !== 1'b0 || bus.RAM2_OE !== 1'b0) begin
      errors++; $display("FAIL fin_hold got done=%b WE3=%b OE2=%b required 1/0/0",
                         done, bus.RAM3_WE, bus.RAM2_OE);
    end
  endtask

  task automatic test_entry63();
    int dc;
    load_pattern();
    ram1[CB_SIZE-1] = 24'hABCDEF;
    for (int j = 0; j < NUM_PIX; j++) ram2[j] = 24'd63;
    build_expected();
    apply_reset();
    release_and_wait(dc);
    checks++;
    if (dc != 4163) begin
      errors++; $display("FAIL e63_done_cycle got %0d required 4163", dc);
    end
    checks++;
    if (ram3[0] !== 24'hABCDEF || ram3[NUM_PIX-1] !== 24'hABCDEF) begin
      errors++; $display("FAIL e63_boundary got first=%h last=%h required abcdef", ram3[0], ram3[NUM_PIX-1]);
    end
    checks++;
    if (count_mismatch() != 0) begin
      errors++; $display("FAIL e63_contents got %0d bad words required 0", count_mismatch());
    end
  endtask

  task automatic test_upper_tag();
    int dc;
    load_pattern();
    ram2[100] = 24'h000105;
    build_expected();
    apply_reset();
    release_and_wait(dc);
    checks++;
    if (dc != 4163) begin
      errors++; $display("FAIL upper_done_cycle got %0d required 4163", dc);
    end
`ifdef DECOMP_TAG_CHECK_EN
    checks++;
    if (ram3[100] !== 24'h000000) begin
      errors++; $display("FAIL upper_pixel got %h required 000000", ram3[100]);
    end
    checks++;
    if (tagerr_cyc != 167) begin
      errors++; $display("FAIL tag_err_rise got cyc %0d required 167", tagerr_cyc);
    end
    checks++;
    if (tag_err !== 1'b1) begin
      errors++; $display("FAIL tag_err_sticky got %b required 1", tag_err);
    end
`else
    checks++;
    if (ram3[100] !== 24'h05FA5F) begin
      errors++; $display("FAIL upper_pixel got %h required 05fa5f", ram3[100]);
    end
`endif
    checks++;
    if (count_mismatch() != 0) begin
      errors++; $display("FAIL upper_contents got %0d bad words required 0", count_mismatch());
    end
  endtask

  task automatic test_mid_reset();
    int dc;
    bit reached;
    load_pattern();
    build_expected();
    apply_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < MAX_CYC && !reached; i++) begin
      @(negedge clk);
      if (edges == 2000) reached = 1'b1;
    end
    checks++;
    if (!reached) begin
      errors++; $display("FAIL midrst_reach got timeout required cycle 2000");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.RAM1_OE, bus.RAM2_OE, bus.RAM3_WE, done} !== 4'b0 || bus.RAM2_A !== '0 ||
        bus.RAM3_A !== '0 || bus.RAM3_D !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got OE2=%b A2=%h WE3=%b A3=%h D3=%h done=%b, required all 0",
               bus.RAM2_OE, bus.RAM2_A, bus.RAM3_WE, bus.RAM3_A, bus.RAM3_D, done);
    end
    for (int j = 0; j < NUM_PIX; j++) ram3[j] = 'x;
    repeat (2) @(posedge clk);
    release_and_wait(dc);
    checks++;
    if (dc != 4163) begin
      errors++; $display("FAIL midrst_done_cycle got %0d required 4163", dc);
    end
    checks++;
    if (wr_count != NUM_PIX || first_we_cyc != 67) begin
      errors++; $display("FAIL midrst_writes got count=%0d first=%0d required 4096/67", wr_count, first_we_cyc);
    end
    checks++;
    if (count_mismatch() != 0) begin
      errors++; $display("FAIL midrst_contents got %0d bad words required 0", count_mismatch());
    end
  endtask

  initial begin
    bus.RAM1_Q = '0;
    bus.RAM2_Q = '0;
    test_reset();
    test_pattern();
    test_entry63();
    test_upper_tag();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decompressor.md
# decompressor

Decoder side of the codebook image codec: reads the 64-entry RGB codebook from RAM1 into a local register file, then streams the 4096 per-pixel tags from RAM2, looks up each tag's codeword and writes the reconstructed 24-bit pixel to RAM3. It is a standalone top-level, driven by the testbench's external RAMs exactly as the compressor is, and signals `done` when the last pixel is written.

## Interface
- CB_SIZE, 64, number of codewords loaded from RAM1
- TAG_W, 6, tag index width (log2 CB_SIZE)
- NUM_PIX, 4096, number of tags/pixels
- DATA_W, 24, RAM data width (R[23:16], G[15:8], B[7:0])
- ADDR_W, 20, RAM address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- RAM1_Q  in  DATA_W  codebook read data
- RAM1_A  out  ADDR_W  codebook read address
- RAM1_OE  out  1  codebook read enable
- RAM1_WE / RAM1_D  out  1 / DATA_W  tied 0
- RAM2_Q  in  DATA_W  tag word; index in [TAG_W-1:0]
- RAM2_A  out  ADDR_W  tag read address
- RAM2_OE  out  1  tag read enable
- RAM2_WE / RAM2_D  out  1 / DATA_W  tied 0
- RAM3_D  out  DATA_W  reconstructed pixel
- RAM3_A  out  ADDR_W  pixel write address
- RAM3_WE  out  1  pixel write strobe
- RAM3_OE  out  1  tied 0
- done  out  1  sticky completion flag

## Operation
- External RAMs: synchronous read, Q valid the cycle after A/OE presented; write on the clock edge where WE=1.
- States: IDLE -> LOAD_CB -> DECODE -> DRAIN -> FIN.
- IDLE: one cycle after reset release, then LOAD_CB.
- LOAD_CB: RAM1_OE=1, RAM1_A = 0..CB_SIZE-1, one per cycle; RAM1_Q captured into codebook entry k one cycle after address k. After address CB_SIZE-1 -> DECODE.
- DECODE: RAM2_OE=1, RAM2_A = 0..NUM_PIX-1, one per cycle; the tag returned next cycle indexes the codebook combinationally; result registered onto RAM3_D/RAM3_A with RAM3_WE=1. After address NUM_PIX-1 -> DRAIN.
- DRAIN: two cycles to flush the read and write stages -> FIN.
- FIN: done=1, all enables 0, held until reset.
- The codebook write of entry CB_SIZE-1 and the first tag lookup never collide: entry 63 is written before tag 0 data returns.
- Tag bits above TAG_W-1 are ignored (default build).
- Address counters are ADDR_W wide, zero-extended; no wrap occurs (terminal compares at CB_SIZE-1 / NUM_PIX-1).

## Timing
- Reset values: every output 0, state IDLE, counters 0, codebook entries 0.
- Counting cycle 0 as the first edge after rst falls: IDLE cycle 0; RAM1 addresses 0..63 in cycles 1..64; RAM2 addresses 0..4095 in cycles 65..4160.
- Pixel j: RAM3_WE=1, RAM3_A=j in cycle 67+j; last write cycle 4162; done=1 from cycle 4163.
- Read-to-write latency 2 cycles; throughput 1 pixel/cycle, no bubbles.
- rst asserted mid-operation: all outputs drop to 0 immediately (asynchronously), the codebook clears, and the sequence restarts from IDLE on release; no partial write is completed.

## Configuration
- DECOMP_TAG_CHECK_EN defined: a RAM2_Q word with any bit [DATA_W-1:TAG_W] nonzero writes 24'h000000 instead of the codeword, and sets an extra output tag_err (1 bit, reset 0, sticky until reset), which is raised in the same cycle as that pixel's write.
- Undefined: upper tag bits are ignored, the tag_err port does not exist, and the decoder always writes the codeword.

## Structure
- Package decomp_pkg: state encoding (IDLE, LOAD_CB, DECODE, DRAIN, FIN), CB_SIZE, TAG_W, NUM_PIX, DATA_W, ADDR_W defaults.
- Sub-module cb_regfile: CB_SIZE×DATA_W flops, one synchronous write port, one combinational read port, async clear on rst.
- Top holds the FSM, address counters and output pipeline registers.

## Test plan
- Codebook entry k = {k, ~k, k^8'h5A} (8-bit fields); tags j mod 64 -> RAM3[j] = codebook[j mod 64] for all 4096 pixels; done first high in cycle 4163.
- All tags = 63, entry 63 = 24'hABCDEF -> every RAM3 word = 24'hABCDEF (checks the entry-63/tag-0 boundary).
- Tag word 24'h000105 with DECOMP_TAG_CHECK_EN undefined -> writes codebook[5]. With it defined -> writes 24'h000000 and tag_err rises in that write cycle, then stays high.
- Reset pulse at cycle 2000: all outputs 0 in the same cycle; after release, a full correct decode with done at cycle 4163 relative to the new release.
- Checker on every cycle: RAM1_WE, RAM2_WE, RAM3_OE are 0. RAM3_WE is high for exactly 4096 cycles, with addresses strictly increasing 0..4095.
